param_register_file: RTL and testbench

//  Parametrised multi-port integer register file with write-back scoreboard and read bypass.

---
 rtl/param_register_file.sv | 124 ++++++++++++
 tb/tb_param_register_file.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// ============================================================================
// param_register_file : multi-port register file, busy scoreboard, read bypass
// Revision: 1.0
// ============================================================================
`default_nettype none

module param_register_file #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int ZERO_REG     = 1,
  parameter int BYPASS       = 1,
  localparam int IDX_W       = $clog2(NUM_REGS)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_RD_PORTS*IDX_W-1:0]  rd_idx_in,
  output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data_out,
  output logic [NUM_RD_PORTS-1:0]        rd_busy_out,
  input  logic [NUM_WR_PORTS-1:0]        wr_en_in,
  input  logic [NUM_WR_PORTS*IDX_W-1:0]  wr_idx_in,
  input  logic [NUM_WR_PORTS*XLEN-1:0]   wr_data_in,
  input  logic                           claim_en_in,
  input  logic [IDX_W-1:0]               claim_idx_in,
  input  logic                           flush_in,
  output logic                           wr_conflict_out
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                conflict_q;
  logic                conflict_d;

  logic [IDX_W-1:0]    w_wr_idx  [NUM_WR_PORTS];
  logic [XLEN-1:0]     w_wr_data [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] w_wr_ok;

  generate
    for (genvar k = 0; k < NUM_WR_PORTS; k++) begin : g_wr_unpack
      assign w_wr_idx[k]  = wr_idx_in[k*IDX_W +: IDX_W];
      assign w_wr_data[k] = wr_data_in[k*XLEN +: XLEN];
      // A write port is effective only if enabled and not aimed at a hardwired x0
      assign w_wr_ok[k]   = wr_en_in[k] && !((ZERO_REG != 0) && (w_wr_idx[k] == '0));
    end
  endgenerate

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    conflict_d = 1'b0;
    // Ascending port order so the highest-numbered port lands last and wins
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (w_wr_ok[k]) begin
        regs_d[w_wr_idx[k]] = w_wr_data[k];
        busy_d[w_wr_idx[k]] = 1'b0;
      end
    end
    if (flush_in) begin
      busy_d = '0;
    end else if (claim_en_in && !((ZERO_REG != 0) && (claim_idx_in == '0))) begin
      busy_d[claim_idx_in] = 1'b1;
    end
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
        if (w_wr_ok[i] && w_wr_ok[j] && (w_wr_idx[i] == w_wr_idx[j])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign wr_conflict_out = conflict_q;

  generate
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
      logic [IDX_W-1:0] ridx;
      logic [XLEN-1:0]  data;
      logic             busy;

      assign ridx = rd_idx_in[p*IDX_W +: IDX_W];

      always_comb begin
        data = regs_q[ridx];
        busy = busy_q[ridx];
        if (BYPASS != 0) begin
          for (int k = 0; k < NUM_WR_PORTS; k++) begin
            if (wr_en_in[k] && (w_wr_idx[k] == ridx)) begin
              data = w_wr_data[k];
              busy = 1'b0;
            end
          end
        end
        // Reset gating keeps bypassed write data from leaking out while rst_in is high
        if (((ZERO_REG != 0) && (ridx == '0)) || rst_in) begin
          data = '0;
          busy = 1'b0;
        end
      end

      assign rd_data_out[p*XLEN +: XLEN] = data;
      assign rd_busy_out[p]              = busy;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_param_register_file.sv
// ============================================================================
// tb_param_register_file : directed vectors, corner sequences, random vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_param_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_idx;
  logic [63:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_idx;
  logic        flush;
  logic        conflict;

  logic [9:0]  nb_rd_idx;
  logic [63:0] nb_rd_data;
  logic [1:0]  nb_rd_busy;
  logic [1:0]  nb_wr_en;
  logic [9:0]  nb_wr_idx;
  logic [63:0] nb_wr_data;
  logic        nb_claim_en;
  logic [4:0]  nb_claim_idx;
  logic        nb_flush;
  logic        nb_conflict;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_register_file dut (
    .clk_in(clk), .rst_in(rst),
    .rd_idx_in(rd_idx), .rd_data_out(rd_data), .rd_busy_out(rd_busy),
    .wr_en_in(wr_en), .wr_idx_in(wr_idx), .wr_data_in(wr_data),
    .claim_en_in(claim_en), .claim_idx_in(claim_idx),
    .flush_in(flush), .wr_conflict_out(conflict)
  );

  param_register_file #(.BYPASS(0)) dut_nb (
    .clk_in(clk), .rst_in(rst),
    .rd_idx_in(nb_rd_idx), .rd_data_out(nb_rd_data), .rd_busy_out(nb_rd_busy),
    .wr_en_in(nb_wr_en), .wr_idx_in(nb_wr_idx), .wr_data_in(nb_wr_data),
    .claim_en_in(nb_claim_en), .claim_idx_in(nb_claim_idx),
    .flush_in(nb_flush), .wr_conflict_out(nb_conflict)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wi0;
    logic [31:0] wd0;
    logic [4:0]  wi1;
    logic [31:0] wd1;
    logic        ce;
    logic [4:0]  ci;
    logic        fl;
    logic [4:0]  ri0;
    logic [4:0]  ri1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        ecf;
  } vec_t;

  vec_t vt[27];

  function automatic vec_t mk(logic r, logic [1:0] we, logic [4:0] wi0, logic [31:0] wd0,
                              logic [4:0] wi1, logic [31:0] wd1, logic ce, logic [4:0] ci,
                              logic fl, logic [4:0] ri0, logic [4:0] ri1, logic [31:0] e0,
                              logic [31:0] e1, logic [1:0] eb, logic ecf);
    vec_t v;
    v.rst = r; v.we = we; v.wi0 = wi0; v.wd0 = wd0; v.wi1 = wi1; v.wd1 = wd1;
    v.ce = ce; v.ci = ci; v.fl = fl; v.ri0 = ri0; v.ri1 = ri1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ecf = ecf;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst       = v.rst;
    wr_en     = v.we;
    wr_idx    = {v.wi1, v.wi0};
    wr_data   = {v.wd1, v.wd0};
    claim_en  = v.ce;
    claim_idx = v.ci;
    flush     = v.fl;
    rd_idx    = {v.ri1, v.ri0};
  endtask

  task automatic idle(input logic [4:0] ri0, input logic [4:0] ri1);
    wr_en = 2'b00; wr_idx = '0; wr_data = '0;
    claim_en = 1'b0; claim_idx = '0; flush = 1'b0;
    rd_idx = {ri1, ri0};
  endtask

  task automatic chk(input string nm, input logic [63:0] ad, input logic [1:0] ab,
                     input logic acf, input logic [31:0] e0, input logic [31:0] e1,
                     input logic [1:0] eb, input logic ecf);
    n_vec++;
    if (ad !== {e1, e0} || ab !== eb || acf !== ecf) begin
      n_err++;
      $display("FAIL %s: got data1=%h data0=%h busy=%b conflict=%b, want data1=%h data0=%h busy=%b conflict=%b",
               nm, ad[63:32], ad[31:0], ab, acf, e1, e0, eb, ecf);
    end
  endtask

  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  logic        mcf;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ri;
    logic [31:0] ex  [2];
    logic [1:0]  exb;
    logic [1:0]  we;
    logic [4:0]  wi0, wi1, ci, ri0, ri1;
    logic [31:0] wd0, wd1;
    logic        ce, fl;

    //           rst we     wi0 wd0           wi1 wd1      ce ci fl ri0 ri1 e0            e1       eb     ecf
    vt[0]  = mk(1, 2'b01, 5,  32'hDEADBEEF, 0,  0,       0, 0, 0, 5,  0,  0,            0,       2'b00, 0);
    vt[1]  = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 5,  7,  0,            0,       2'b00, 0);
    vt[2]  = mk(0, 2'b01, 7,  32'h1234,     0,  0,       0, 0, 0, 7,  5,  32'h1234,     0,       2'b00, 0);
    vt[3]  = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 7,  0,  32'h1234,     0,       2'b00, 0);
    vt[4]  = mk(0, 2'b11, 3,  32'hAAAA,     3,  32'h5555,0, 0, 0, 3,  7,  32'h5555,     32'h1234,2'b00, 0);
    vt[5]  = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 3,  3,  32'h5555,     32'h5555,2'b00, 1);
    vt[6]  = mk(0, 2'b11, 0,  1,            0,  2,       0, 0, 0, 0,  3,  0,            32'h5555,2'b00, 0);
    vt[7]  = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 0,  3,  0,            32'h5555,2'b00, 0);
    vt[8]  = mk(0, 2'b00, 0,  0,            0,  0,       1, 9, 0, 9,  9,  0,            0,       2'b00, 0);
    vt[9]  = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 9,  9,  0,            0,       2'b11, 0);
    vt[10] = mk(0, 2'b10, 0,  0,            9,  32'h42,  0, 0, 0, 9,  3,  32'h42,       32'h5555,2'b00, 0);
    vt[11] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 9,  3,  32'h42,       32'h5555,2'b00, 0);
    vt[12] = mk(0, 2'b01, 9,  32'h77,       0,  0,       1, 9, 0, 9,  9,  32'h77,       32'h77,  2'b00, 0);
    vt[13] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 9,  3,  32'h77,       32'h5555,2'b01, 0);
    vt[14] = mk(0, 2'b00, 0,  0,            0,  0,       1, 1, 0, 1,  9,  0,            32'h77,  2'b10, 0);
    vt[15] = mk(0, 2'b00, 0,  0,            0,  0,       1, 2, 0, 1,  2,  0,            0,       2'b01, 0);
    vt[16] = mk(0, 2'b00, 0,  0,            0,  0,       1, 3, 0, 2,  3,  0,            32'h5555,2'b01, 0);
    vt[17] = mk(0, 2'b00, 0,  0,            0,  0,       1, 4, 1, 3,  4,  32'h5555,     0,       2'b01, 0);
    vt[18] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 1,  4,  0,            0,       2'b00, 0);
    vt[19] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 2,  3,  0,            32'h5555,2'b00, 0);
    vt[20] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 9,  2,  32'h77,       0,       2'b00, 0);
    vt[21] = mk(0, 2'b01, 0,  32'hFFFFFFFF, 0,  0,       1, 0, 0, 0,  0,  0,            0,       2'b00, 0);
    vt[22] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 0,  9,  0,            32'h77,  2'b00, 0);
    vt[23] = mk(0, 2'b10, 0,  0,            10, 32'hBEEF,0, 0, 1, 10, 0,  32'hBEEF,     0,       2'b00, 0);
    vt[24] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 10, 10, 32'hBEEF,     32'hBEEF,2'b00, 0);
    vt[25] = mk(0, 2'b01, 11, 32'h11,       11, 32'h22,  0, 0, 0, 11, 3,  32'h11,       32'h5555,2'b00, 0);
    vt[26] = mk(0, 2'b00, 0,  0,            0,  0,       0, 0, 0, 11, 11, 32'h11,       32'h11,  2'b00, 0);

    drive(vt[0]);
    nb_wr_en = '0; nb_wr_idx = '0; nb_wr_data = '0; nb_rd_idx = '0;
    nb_claim_en = 1'b0; nb_claim_idx = '0; nb_flush = 1'b0;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("vec%0d", i), rd_data, rd_busy, conflict,
          vt[i].e0, vt[i].e1, vt[i].eb, vt[i].ecf);
    end

    // Asynchronous reset while a colliding write and a claim are pending
    @(negedge clk);
    idle(6, 7);
    wr_en = 2'b11; wr_idx = {5'd6, 5'd6}; wr_data = {32'hBBBB, 32'hAAAA};
    #1 chk("collide6", rd_data, rd_busy, conflict, 32'hBBBB, 32'h1234, 2'b00, 1'b0);
    @(negedge clk);
    idle(6, 5);
    wr_en = 2'b01; wr_idx = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    claim_en = 1'b1; claim_idx = 5'd9;
    #1 chk("pre_rst", rd_data, rd_busy, conflict, 32'hBBBB, 32'hDEADBEEF, 2'b00, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_rst", rd_data, rd_busy, conflict, 32'h0, 32'h0, 2'b00, 1'b0);
    @(posedge clk);
    #1 chk("rst_hold", rd_data, rd_busy, conflict, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(5, 6);
    #1 chk("post_rst_x5x6", rd_data, rd_busy, conflict, 32'h0, 32'h0, 2'b00, 1'b0);
    idle(9, 7);
    #1 chk("post_rst_x9x7", rd_data, rd_busy, conflict, 32'h0, 32'h0, 2'b00, 1'b0);

    // BYPASS=0 instance: new data and busy clear appear only after the edge
    @(negedge clk);
    nb_wr_en = 2'b01; nb_wr_idx = {5'd0, 5'd7}; nb_wr_data = {32'h0, 32'h1234};
    nb_rd_idx = {5'd0, 5'd7};
    #1 chk("nb_same_cycle", nb_rd_data, nb_rd_busy, nb_conflict, 32'h0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    nb_wr_en = 2'b00; nb_claim_en = 1'b1; nb_claim_idx = 5'd9;
    #1 chk("nb_next_cycle", nb_rd_data, nb_rd_busy, nb_conflict, 32'h1234, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    nb_claim_en = 1'b0;
    nb_wr_en = 2'b10; nb_wr_idx = {5'd9, 5'd0}; nb_wr_data = {32'h5, 32'h0};
    nb_rd_idx = {5'd7, 5'd9};
    #1 chk("nb_busy_no_bypass", nb_rd_data, nb_rd_busy, nb_conflict, 32'h0, 32'h1234, 2'b01, 1'b0);
    @(negedge clk);
    nb_wr_en = 2'b00;
    #1 chk("nb_written", nb_rd_data, nb_rd_busy, nb_conflict, 32'h5, 32'h1234, 2'b00, 1'b0);

    // Random mixed traffic on the bypassing instance against a behavioural model
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    mbusy = '0;
    mcf   = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      we  = 2'($urandom_range(0, 3));
      wi0 = 5'($urandom_range(0, 7));
      wi1 = 5'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      ce  = 1'($urandom_range(0, 1));
      ci  = 5'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 15) == 0);
      ri0 = 5'($urandom_range(0, 7));
      ri1 = 5'($urandom_range(0, 7));
      wr_en = we; wr_idx = {wi1, wi0}; wr_data = {wd1, wd0};
      claim_en = ce; claim_idx = ci; flush = fl; rd_idx = {ri1, ri0};
      for (int p = 0; p < 2; p++) begin
        ri = (p == 0) ? ri0 : ri1;
        ex[p]  = mregs[ri];
        exb[p] = mbusy[ri];
        if (we[0] && wi0 == ri) begin ex[p] = wd0; exb[p] = 1'b0; end
        if (we[1] && wi1 == ri) begin ex[p] = wd1; exb[p] = 1'b0; end
        if (ri == 5'd0) begin ex[p] = '0; exb[p] = 1'b0; end
      end
      #1 chk($sformatf("rand%0d", cyc), rd_data, rd_busy, conflict, ex[0], ex[1], exb, mcf);
      mcf = (we == 2'b11) && (wi0 == wi1) && (wi0 != 5'd0);
      if (we[0] && wi0 != 5'd0) mregs[wi0] = wd0;
      if (we[1] && wi1 != 5'd0) mregs[wi1] = wd1;
      if (fl) begin
        mbusy = '0;
      end else begin
        if (we[0]) mbusy[wi0] = 1'b0;
        if (we[1]) mbusy[wi1] = 1'b0;
        if (ce && ci != 5'd0) mbusy[ci] = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
